// File: rtl/uart_pkg.sv
// Shared UART constants and baud divisor computation.
// Used by the baud generator and the TX/RX blocks.
package uart_pkg;

  localparam int unsigned OVERSAMPLE_DEF = 16;
  localparam int unsigned FRAC_BITS_DEF  = 4;

  // Fixed-point clocks per sample tick, rounded down:
  // clk_freq * 2^frac_bits / (baud * oversample).
  function automatic longint unsigned calc_divisor(
    input longint unsigned clk_freq,
    input longint unsigned baud,
    input longint unsigned oversample,
    input int unsigned     frac_bits
  );
    return (clk_freq << frac_bits) / (baud * oversample);
  endfunction

endpackage

// File: rtl/uart_baud_generator_tick_counter.sv
// Modulo-OVERSAMPLE sample index with bit-centre/bit-end decode.
// Ports: clk, reset, clr, adv in; mid_tick, bit_tick out.
module uart_tick_counter
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic adv,
  output logic mid_tick,
  output logic bit_tick
);

  localparam int unsigned IW = $clog2(OVERSAMPLE);
  localparam logic [IW-1:0] MID_IDX =
    IW'(OVERSAMPLE / 2 - 1);
  localparam logic [IW-1:0] END_IDX =
    IW'(OVERSAMPLE - 1);

  logic [IW-1:0] idx;

  // Power-of-two OVERSAMPLE lets the index wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx      <= '0;
      mid_tick <= 1'b0;
      bit_tick <= 1'b0;
    end else if (clr) begin
      idx      <= '0;
      mid_tick <= 1'b0;
      bit_tick <= 1'b0;
    end else begin
      mid_tick <= adv && (idx == MID_IDX);
      bit_tick <= adv && (idx == END_IDX);
      if (adv) begin
        idx <= idx + IW'(1);
      end
    end
  end

endmodule

// File: rtl/uart_baud_generator.sv
// Fractional-N UART baud tick generator.
// Ports: clk, reset, enable, resync, div_wr, div_int,
//   div_frac in; sample_tick, mid_tick, bit_tick out.
module uart_baud_generator
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = 100000000,
  parameter int unsigned DEFAULT_BAUD = 9600,
  parameter int unsigned OVERSAMPLE   = OVERSAMPLE_DEF,
  parameter int unsigned DIV_WIDTH    = 16,
  parameter int unsigned FRAC_BITS    = FRAC_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 resync,
  input  logic                 div_wr,
  input  logic [DIV_WIDTH-1:0] div_int,
  input  logic [FRAC_BITS-1:0] div_frac,
  output logic                 sample_tick,
  output logic                 mid_tick,
  output logic                 bit_tick
);

  localparam longint unsigned RST_DIV = calc_divisor(
    64'(CLK_FREQ), 64'(DEFAULT_BAUD),
    64'(OVERSAMPLE), FRAC_BITS);
  localparam logic [DIV_WIDTH-1:0] RST_INT =
    DIV_WIDTH'(RST_DIV >> FRAC_BITS);
  localparam logic [FRAC_BITS-1:0] RST_FRAC =
    FRAC_BITS'(RST_DIV);

  // One extra bit so a long period at max div_int fits.
  localparam int unsigned CW = DIV_WIDTH + 1;

  logic [DIV_WIDTH-1:0] act_int;
  logic [DIV_WIDTH-1:0] shd_int;
  logic [DIV_WIDTH-1:0] eff_int;
  logic [FRAC_BITS-1:0] act_frac;
  logic [FRAC_BITS-1:0] shd_frac;
  logic [FRAC_BITS-1:0] acc;
  logic [FRAC_BITS:0]   sum;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        term;
  logic                 pend;
  logic                 long_q;
  logic                 clr;
  logic                 at_end;

  assign eff_int = (act_int < DIV_WIDTH'(2))
                 ? DIV_WIDTH'(2) : act_int;
  assign term = {1'b0, eff_int} + CW'(long_q)
              - CW'(1);
  assign sum = {1'b0, acc} + {1'b0, act_frac};
  assign clr = !enable || resync;
  assign at_end = !clr && (cnt == term);

  // A write during a running period waits in the shadow
  // until the period ends; when idle or resyncing, it
  // takes effect at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      act_int     <= RST_INT;
      act_frac    <= RST_FRAC;
      shd_int     <= '0;
      shd_frac    <= '0;
      pend        <= 1'b0;
      cnt         <= '0;
      acc         <= '0;
      long_q      <= 1'b0;
      sample_tick <= 1'b0;
    end else begin
      sample_tick <= at_end;
      if (!enable) begin
        cnt    <= '0;
        acc    <= '0;
        long_q <= 1'b0;
        pend   <= 1'b0;
        if (div_wr) begin
          act_int  <= div_int;
          act_frac <= div_frac;
        end else if (pend) begin
          act_int  <= shd_int;
          act_frac <= shd_frac;
        end
      end else if (resync) begin
        cnt    <= '0;
        acc    <= '0;
        long_q <= 1'b0;
        if (div_wr) begin
          act_int  <= div_int;
          act_frac <= div_frac;
          pend     <= 1'b0;
        end
      end else if (at_end) begin
        cnt    <= '0;
        acc    <= sum[FRAC_BITS-1:0];
        long_q <= sum[FRAC_BITS];
        pend   <= 1'b0;
        if (div_wr) begin
          act_int  <= div_int;
          act_frac <= div_frac;
        end else if (pend) begin
          act_int  <= shd_int;
          act_frac <= shd_frac;
        end
      end else begin
        cnt <= cnt + CW'(1);
        if (div_wr) begin
          shd_int  <= div_int;
          shd_frac <= div_frac;
          pend     <= 1'b1;
        end
      end
    end
  end

  uart_tick_counter #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_tick (
    .clk      (clk),
    .reset    (reset),
    .clr      (clr),
    .adv      (at_end),
    .mid_tick (mid_tick),
    .bit_tick (bit_tick)
  );

endmodule

// File: tb/tb_uart_baud_generator.sv
// Self-checking bench for uart_baud_generator.
// Countdown model plus directed interval checks.
module tb_uart_baud_generator;

  localparam int OS      = 16;
  localparam int FW      = 16;
  localparam int RST_INT = 651;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        resync;
  logic        div_wr;
  logic [15:0] div_int;
  logic [3:0]  div_frac;
  logic        sample_tick;
  logic        mid_tick;
  logic        bit_tick;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  uart_baud_generator dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .resync      (resync),
    .div_wr      (div_wr),
    .div_int     (div_int),
    .div_frac    (div_frac),
    .sample_tick (sample_tick),
    .mid_tick    (mid_tick),
    .bit_tick    (bit_tick)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  function automatic int eff(input int d);
    return (d < 2) ? 2 : d;
  endfunction

  // Model: cycles remaining in the current period,
  // fractional remainder in sixteenths, ticks in the bit.
  int m_int, m_frac, s_int, s_frac;
  int rem, m_acc, m_long, tno, tot;
  bit pend;
  bit ready = 1'b0;
  logic e_s = 1'b0;
  logic e_m = 1'b0;
  logic e_b = 1'b0;

  task automatic m_apply();
    if (div_wr) begin
      m_int  = int'(div_int);
      m_frac = int'(div_frac);
      pend   = 1'b0;
    end else if (pend) begin
      m_int  = s_int;
      m_frac = s_frac;
      pend   = 1'b0;
    end
  endtask

  initial begin : model
    forever begin
      @(posedge clk);
      ready = 1'b1;
      e_s = 1'b0;
      e_m = 1'b0;
      e_b = 1'b0;
      if (reset) begin
        m_int = RST_INT;
        m_frac = 0;
        pend = 1'b0;
        m_acc = 0;
        m_long = 0;
        tno = 0;
        rem = eff(m_int);
      end else if (!enable) begin
        m_apply();
        pend = 1'b0;
        m_acc = 0;
        m_long = 0;
        tno = 0;
        rem = eff(m_int);
      end else if (resync) begin
        if (div_wr) m_apply();
        m_acc = 0;
        m_long = 0;
        tno = 0;
        rem = eff(m_int);
      end else begin
        rem--;
        if (rem == 0) begin
          e_s = 1'b1;
          tno++;
          e_m = ((tno % OS) == OS / 2);
          e_b = ((tno % OS) == 0);
          tot = m_acc + m_frac;
          m_long = (tot >= FW) ? 1 : 0;
          m_acc = tot % FW;
          m_apply();
          rem = eff(m_int) + m_long;
        end else if (div_wr) begin
          s_int  = int'(div_int);
          s_frac = int'(div_frac);
          pend   = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (ready && !reset) begin
      chk("sample_tick", {31'b0, sample_tick},
          {31'b0, e_s});
      chk("mid_tick", {31'b0, mid_tick},
          {31'b0, e_m});
      chk("bit_tick", {31'b0, bit_tick},
          {31'b0, e_b});
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // sel: 0 sample, 1 mid, 2 bit. n = edges, t = ticks.
  task automatic wait_evt(input int sel,
                          input int lim,
                          output int n,
                          output int t);
    logic hit;
    n = 0;
    t = 0;
    hit = 1'b0;
    while (!hit && n < lim) begin
      step();
      n++;
      if (sample_tick) t++;
      case (sel)
        0:       hit = sample_tick;
        1:       hit = mid_tick;
        default: hit = bit_tick;
      endcase
    end
    chk("evt_in_time", {31'b0, hit}, 32'd1);
  endtask

  task automatic wait_tick(input int lim,
                           output int n);
    int t;
    wait_evt(0, lim, n, t);
  endtask

  task automatic load(input int di, input int df);
    enable = 1'b0;
    div_int = 16'(di);
    div_frac = 4'(df);
    div_wr = 1'b1;
    step();
    div_wr = 1'b0;
    step();
    enable = 1'b1;
  endtask

  initial begin : stim
    int n, t, s;
    reset = 1'b1;
    enable = 1'b0;
    resync = 1'b0;
    div_wr = 1'b0;
    div_int = '0;
    div_frac = '0;
    repeat (3) step();
    chk("rst_sample", {31'b0, sample_tick}, 32'd0);
    chk("rst_mid", {31'b0, mid_tick}, 32'd0);
    chk("rst_bit", {31'b0, bit_tick}, 32'd0);
    reset = 1'b0;
    step();

    // Default 9600 baud: divisor 651 r0.
    enable = 1'b1;
    wait_tick(1000, n);
    chk("first_tick_cycle", n + 1, 652);
    wait_tick(1000, n);
    chk("period_651", n, 651);
    wait_evt(2, 12000, n, t);
    wait_evt(2, 12000, n, t);
    chk("bit_10416", n, 10416);
    chk("ticks_per_bit", t, 16);

    // 115200 baud: 54 + 4/16.
    load(54, 4);
    wait_evt(2, 2000, n, t);
    wait_evt(2, 2000, n, t);
    chk("bit_868", n, 868);
    wait_evt(1, 2000, n, t);
    chk("mid_434", n, 434);
    wait_evt(2, 2000, n, t);
    chk("mid_to_bit_434", n, 434);
    s = 0;
    for (int i = 0; i < 4; i++) begin
      wait_tick(100, n);
      s += n;
    end
    chk("four_ticks_217", s, 217);

    // Shadow write mid-period.
    load(54, 0);
    wait_tick(100, n);
    repeat (20) step();
    div_int = 16'd10;
    div_wr = 1'b1;
    step();
    div_wr = 1'b0;
    wait_tick(100, n);
    chk("old_period_54", n + 21, 54);
    wait_tick(100, n);
    chk("new_period_10", n, 10);
    wait_tick(100, n);
    chk("new_period_10b", n, 10);

    // Resync at index 7, on the would-be tick edge.
    load(54, 0);
    for (int i = 0; i < 7; i++) wait_tick(100, n);
    repeat (53) step();
    resync = 1'b1;
    step();
    resync = 1'b0;
    chk("resync_no_tick", {31'b0, sample_tick}, 32'd0);
    wait_tick(100, n);
    chk("resync_period", n, 54);
    wait_evt(2, 2000, n, t);
    chk("resync_bit_ticks", t + 1, 16);

    // Resync together with a divisor write.
    repeat (5) step();
    div_int = 16'd20;
    div_wr = 1'b1;
    resync = 1'b1;
    step();
    div_wr = 1'b0;
    resync = 1'b0;
    wait_tick(100, n);
    chk("resync_wr_20", n, 20);

    // Clamp of tiny divisors.
    load(0, 0);
    wait_tick(20, n);
    wait_tick(20, n);
    chk("clamp_0", n, 2);
    load(1, 0);
    wait_tick(20, n);
    wait_tick(20, n);
    chk("clamp_1", n, 2);

    // Async reset while bit_tick is high.
    wait_evt(2, 100, n, t);
    reset = 1'b1;
    #1;
    chk("arst_sample", {31'b0, sample_tick}, 32'd0);
    chk("arst_bit", {31'b0, bit_tick}, 32'd0);
    chk("arst_mid", {31'b0, mid_tick}, 32'd0);
    step();
    reset = 1'b0;
    wait_tick(1000, n);
    chk("post_rst_651", n + 1, 652);
    wait_tick(1000, n);
    chk("post_rst_period", n, 651);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
